// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types for the LDM/STM block-transfer sequencer: FSM states, register
// constants and the {P,U} addressing-mode encoding.
package ldm_stm_sequencer_pkg;

  localparam logic [3:0] PC_IDX     = 4'd15;
  localparam int         WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    FLUSH = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Encoded directly as {pre, up}
  typedef enum logic [1:0] {
    AM_DA = 2'b00,
    AM_IA = 2'b01,
    AM_DB = 2'b10,
    AM_IB = 2'b11
  } amode_t;

  function automatic amode_t amode_of(input logic pre, input logic up);
    return amode_t'({pre, up});
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Command, regfile-port, memory-port and status bundle of the LDM/STM sequencer.
// master = the sequencer (initiator); slave = core/regfile/memory side.
interface ldm_stm_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
);
  localparam int IW = $clog2(NREGS);

  logic              start;
  logic              is_load;
  logic              pre;
  logic              up;
  logic              wb;
  logic [IW-1:0]     rn;
  logic [NREGS-1:0]  reglist;
  logic [DATA_W-1:0] base;

  logic [IW-1:0]     rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [IW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic              pc_we;
  logic [DATA_W-1:0] pc_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              done;

  modport master (
    input  start, is_load, pre, up, wb, rn, reglist, base,
    input  rf_rdata, mem_ack, mem_rdata,
    output rf_raddr, rf_waddr, rf_wdata, rf_we, pc_we, pc_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    output start, is_load, pre, up, wb, rn, reglist, base,
    output rf_rdata, mem_ack, mem_rdata,
    input  rf_raddr, rf_waddr, rf_wdata, rf_we, pc_we, pc_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy, done
  );

endinterface

// File: rtl/ldm_stm_sequencer_reglist_scan.sv
// Combinational register-list scan: popcount plus lowest-set-bit index.
// Zero latency; no handshake.
module ldm_stm_sequencer_reglist_scan #(
  parameter int NREGS = 16,
  parameter int IW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic [NREGS-1:0] i_mask,
  output logic [CW-1:0]    o_cnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  // Walking downward lets the lowest set bit win the index
  always_comb begin
    o_cnt = '0;
    o_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      o_cnt = o_cnt + CW'(i_mask[i]);
      if (i_mask[i]) o_idx = IW'(i);
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer engine driving the regfile and data-memory ports.
// Latency: done at start+4+transfers (start+2 for an empty list); each transfer waits on mem_ack.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input logic                 clk,
  input logic                 rst,
  ldm_stm_sequencer_if.master io_bus
);

  localparam int                IW     = $clog2(NREGS);
  localparam int                CW     = $clog2(NREGS + 1);
  localparam logic [IW-1:0]     PC_REG = IW'(PC_IDX);
  localparam logic [DATA_W-1:0] STEP   = DATA_W'(WORD_BYTES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_is_load;
  logic              r_pre;
  logic              r_up;
  logic              r_wb;
  logic [IW-1:0]     r_rn;
  logic [NREGS-1:0]  r_list;
  logic [NREGS-1:0]  r_mask;
  logic [DATA_W-1:0] r_base;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_final;
  logic              r_pend_vld;
  logic [IW-1:0]     r_pend_idx;
  logic [DATA_W-1:0] r_pend_dat;

  logic [CW-1:0]     w_cnt;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic [DATA_W-1:0] w_span;
  logic [DATA_W-1:0] w_start;
  logic [DATA_W-1:0] w_final;
  logic              w_base_wr;

  logic [IW-1:0]     w_rf_raddr;
  logic [IW-1:0]     w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic              w_rf_we;
  logic              w_pc_we;
  logic [DATA_W-1:0] w_pc_wdata;
  logic              w_mem_req;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_done;

  // One scanner serves both SETUP (full count) and XFER (remaining count/next reg)
  ldm_stm_sequencer_reglist_scan #(.NREGS(NREGS), .IW(IW), .CW(CW)) u_scan (
    .i_mask (r_mask),
    .o_cnt  (w_cnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_span  = DATA_W'(w_cnt) * STEP;
  assign w_final = r_up ? r_base + w_span : r_base - w_span;

  always_comb begin
    w_start = r_base;
    case (amode_of(r_pre, r_up))
      AM_IA:   w_start = r_base;
      AM_IB:   w_start = r_base + STEP;
      AM_DA:   w_start = r_base - w_span + STEP;
      AM_DB:   w_start = r_base - w_span;
      default: w_start = r_base;
    endcase
  end

  // A loaded base register keeps the loaded value; PC never takes a writeback
  assign w_base_wr = r_wb && (r_rn != PC_REG) && !(r_is_load && r_list[r_rn]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rf_raddr  = '0;
    w_rf_waddr  = '0;
    w_rf_wdata  = '0;
    w_rf_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_wdata  = '0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_done      = 1'b0;

    // Load write-back lags its ack by one cycle; never coincides with WB
    if (r_pend_vld) begin
      if (r_pend_idx == PC_REG) begin
        w_pc_we    = 1'b1;
        w_pc_wdata = r_pend_dat & ~DATA_W'(3);
      end else begin
        w_rf_we    = 1'b1;
        w_rf_waddr = r_pend_idx;
        w_rf_wdata = r_pend_dat;
      end
    end

    case (r_state)
      IDLE: if (io_bus.start) w_state_nxt = SETUP;
      SETUP: w_state_nxt = w_any ? XFER : DONE;
      XFER: begin
        w_mem_req  = 1'b1;
        w_mem_we   = !r_is_load;
        w_mem_addr = r_addr;
        if (!r_is_load) begin
          w_rf_raddr  = w_idx;
          w_mem_wdata = io_bus.rf_rdata;
        end
        if (io_bus.mem_ack && (w_cnt == CW'(1))) w_state_nxt = FLUSH;
      end
      FLUSH: w_state_nxt = WB;
      WB: begin
        if (w_base_wr) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = r_rn;
          w_rf_wdata = r_final;
        end
        w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_load  <= 1'b0;
      r_pre      <= 1'b0;
      r_up       <= 1'b0;
      r_wb       <= 1'b0;
      r_rn       <= '0;
      r_list     <= '0;
      r_mask     <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_final    <= '0;
      r_pend_vld <= 1'b0;
      r_pend_idx <= '0;
      r_pend_dat <= '0;
    end else begin
      r_pend_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_is_load <= io_bus.is_load;
            r_pre     <= io_bus.pre;
            r_up      <= io_bus.up;
            r_wb      <= io_bus.wb;
            r_rn      <= io_bus.rn;
            r_list    <= io_bus.reglist;
            r_mask    <= io_bus.reglist;
            r_base    <= io_bus.base;
          end
        end
        SETUP: begin
          r_addr  <= w_start;
          r_final <= w_final;
        end
        XFER: begin
          if (io_bus.mem_ack) begin
            r_mask <= r_mask & (r_mask - NREGS'(1));
            r_addr <= r_addr + STEP;
            if (r_is_load) begin
              r_pend_vld <= 1'b1;
              r_pend_idx <= w_idx;
              r_pend_dat <= io_bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.rf_raddr  = w_rf_raddr;
  assign io_bus.rf_waddr  = w_rf_waddr;
  assign io_bus.rf_wdata  = w_rf_wdata;
  assign io_bus.rf_we     = w_rf_we;
  assign io_bus.pc_we     = w_pc_we;
  assign io_bus.pc_wdata  = w_pc_wdata;
  assign io_bus.mem_req   = w_mem_req;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;
  assign io_bus.busy      = (r_state != IDLE);
  assign io_bus.done      = w_done;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: reference model queues expected memory, regfile,
// PC and done events; a monitor pops and compares whatever the DUT presents.
module tb_ldm_stm_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ldm_stm_sequencer_if #(.DATA_W(32), .NREGS(16)) bus ();

  ldm_stm_sequencer #(.DATA_W(32), .NREGS(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } mem_ev_t;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } rf_ev_t;

  mem_ev_t     q_mem[$];
  rf_ev_t      q_rf[$];
  logic [31:0] q_pc[$];
  int          q_done[$];
  int          q_delay[$];

  logic [31:0] regs[16];
  logic [31:0] mem_img[logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;

  assign bus.rf_rdata = regs[bus.rf_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic logic [31:0] memread(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: each transfer takes its wait count from q_delay
  int wait_left = -1;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wait_left < 0) wait_left = (q_delay.size() > 0) ? q_delay.pop_front() : 0;
      if (wait_left == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = memread(bus.mem_addr);
        wait_left     = -1;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        wait_left--;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      wait_left     = -1;
    end
  end

  // Monitor
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  always @(negedge clk) begin
    mem_ev_t me;
    rf_ev_t  re;
    logic [31:0] pe;
    int      de;
    #2;
    if (bus.mem_req) begin
      if (prev_wait) begin
        chk("hold mem_addr", bus.mem_addr, prev_addr);
        chk("hold mem_we", 32'(bus.mem_we), 32'(prev_we));
        chk("hold mem_wdata", bus.mem_wdata, prev_wdata);
      end
      if (bus.mem_ack) begin
        if (q_mem.size() == 0) unexpected("mem transfer");
        else begin
          me = q_mem.pop_front();
          chk("mem_addr", bus.mem_addr, me.addr);
          chk("mem_we", 32'(bus.mem_we), 32'(me.we));
          if (me.we) chk("mem_wdata", bus.mem_wdata, me.data);
        end
      end
    end
    prev_wait  = bus.mem_req && !bus.mem_ack;
    prev_addr  = bus.mem_addr;
    prev_we    = bus.mem_we;
    prev_wdata = bus.mem_wdata;

    if (bus.rf_we || bus.pc_we) chk("rf_we and pc_we together", 32'(bus.rf_we && bus.pc_we), 32'h0);
    if (bus.rf_we) begin
      if (q_rf.size() == 0) unexpected("rf write");
      else begin
        re = q_rf.pop_front();
        chk("rf_waddr", 32'(bus.rf_waddr), 32'(re.idx));
        chk("rf_wdata", bus.rf_wdata, re.data);
      end
    end
    if (bus.pc_we) begin
      if (q_pc.size() == 0) unexpected("pc write");
      else begin
        pe = q_pc.pop_front();
        chk("pc_wdata", bus.pc_wdata, pe);
      end
    end
    if (bus.done) begin
      if (q_done.size() == 0) unexpected("done");
      else begin
        de = q_done.pop_front();
        chk("done cycle", 32'(cyc), 32'(de));
      end
    end
  end

  task automatic check_leftover(input string tag);
    chk({tag, " leftover mem"}, 32'(q_mem.size()), 32'h0);
    chk({tag, " leftover rf"}, 32'(q_rf.size()), 32'h0);
    chk({tag, " leftover pc"}, 32'(q_pc.size()), 32'h0);
    chk({tag, " leftover done"}, 32'(q_done.size()), 32'h0);
    q_mem.delete();
    q_rf.delete();
    q_pc.delete();
    q_done.delete();
    q_delay.delete();
  endtask

  // Reference model: ascending register order, lowest address from the mode,
  // one load write per register, optional base writeback last.
  task automatic run_op(input logic ld, input logic pre, input logic up, input logic wb,
                        input logic [3:0] rn, input logic [15:0] rl, input logic [31:0] base,
                        input int dly, input bit poke);
    int list[$];
    int n, s, t0, d, k;
    logic [31:0] lo, a, span;
    mem_ev_t me;
    rf_ev_t  re;
    s = 0;
    for (int i = 0; i < 16; i++) if (rl[i]) list.push_back(i);
    n    = list.size();
    span = 32'(4 * n);
    if (up) lo = pre ? base + 32'd4 : base;
    else    lo = pre ? base - span : base - span + 32'd4;
    for (int j = 0; j < n; j++) begin
      a = lo + 32'(4 * j);
      d = (dly >= 0) ? dly : int'($urandom_range(0, 3));
      q_delay.push_back(d);
      s += d + 1;
      me.addr = a;
      me.we   = !ld;
      me.data = ld ? 32'h0 : regs[list[j]];
      q_mem.push_back(me);
      if (ld) begin
        if (list[j] == 15) q_pc.push_back(memread(a) & ~32'h3);
        else begin
          re.idx  = 4'(list[j]);
          re.data = memread(a);
          q_rf.push_back(re);
        end
      end
    end
    if (n > 0 && wb && rn != 4'd15 && !(ld && rl[rn])) begin
      re.idx  = rn;
      re.data = up ? base + span : base - span;
      q_rf.push_back(re);
    end

    @(negedge clk);
    t0 = cyc;
    q_done.push_back(n == 0 ? t0 + 2 : t0 + 4 + s);
    bus.is_load = ld;
    bus.pre     = pre;
    bus.up      = up;
    bus.wb      = wb;
    bus.rn      = rn;
    bus.reglist = rl;
    bus.base    = base;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (poke) begin
      bus.is_load = 1'($urandom);
      bus.wb      = 1'($urandom);
      bus.rn      = 4'($urandom);
      bus.reglist = 16'($urandom);
      bus.base    = $urandom;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    k = 0;
    while (!bus.done && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) unexpected("timeout waiting for done");
    @(negedge clk);
    #3;
    check_leftover("op");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int t0;
    mem_ev_t me;
    rf_ev_t  re;
    bus.start   = 1'b0;
    bus.is_load = 1'b0;
    bus.pre     = 1'b0;
    bus.up      = 1'b0;
    bus.wb      = 1'b0;
    bus.rn      = 4'd0;
    bus.reglist = 16'h0;
    bus.base    = 32'h0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[1]  = 32'd1;
    regs[2]  = 32'd2;
    regs[3]  = 32'd3;
    regs[15] = 32'h0000_1008;
    mem_img[32'h0000_01F8] = 32'h0000_00AA;
    mem_img[32'h0000_01FC] = 32'h0000_00BB;
    mem_img[32'h0000_0048] = 32'h1234_567B;
    mem_img[32'h0000_0080] = 32'h0000_0055;

    repeat (2) @(negedge clk);
    #3;
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset done", 32'(bus.done), 32'h0);
    chk("reset mem_req", 32'(bus.mem_req), 32'h0);
    chk("reset mem_we", 32'(bus.mem_we), 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset mem_wdata", bus.mem_wdata, 32'h0);
    chk("reset rf_we", 32'(bus.rf_we), 32'h0);
    chk("reset rf_raddr", 32'(bus.rf_raddr), 32'h0);
    chk("reset rf_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("reset rf_wdata", bus.rf_wdata, 32'h0);
    chk("reset pc_we", 32'(bus.pc_we), 32'h0);
    chk("reset pc_wdata", bus.pc_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // STM IA R1..R3, zero wait
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h000E, 32'h100, 0, 1'b0);
    // LDM DB with writeback of R13
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 16'h0003, 32'h200, 0, 1'b0);
    // LDM IB into R0 and PC, slow memory
    run_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 16'h8001, 32'h40, 3, 1'b0);
    // LDM with base in list: loaded value wins
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h0004, 32'h80, 0, 1'b0);
    // Empty list, plus a start pulse while busy
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 16'h0000, 32'h300, 0, 1'b1);
    // STM with R15 and base register in list, writeback on, decrement-after
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'h8020, 32'h0000_0004, -1, 1'b1);

    // Reset during the second of four LDM transfers
    q_delay.push_back(0);
    q_delay.push_back(5);
    me.addr = 32'h300; me.we = 1'b0; me.data = 32'h0;
    q_mem.push_back(me);
    re.idx = 4'd0; re.data = memread(32'h300);
    q_rf.push_back(re);
    @(negedge clk);
    t0 = cyc;
    bus.is_load = 1'b1; bus.pre = 1'b0; bus.up = 1'b1; bus.wb = 1'b1;
    bus.rn = 4'd9; bus.reglist = 16'h000F; bus.base = 32'h300;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 4) @(negedge clk);
    #1 rst = 1'b1;
    #3;
    chk("midrst mem_req", 32'(bus.mem_req), 32'h0);
    chk("midrst busy", 32'(bus.busy), 32'h0);
    chk("midrst rf_we", 32'(bus.rf_we), 32'h0);
    chk("midrst mem_addr", bus.mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check_leftover("midrst");
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 16'h000F, 32'h300, 0, 1'b0);

    // Randomized operations
    for (int it = 0; it < 40; it++) begin
      logic [15:0] rl;
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0:       rl = 16'h1 << $urandom_range(0, 15);
        1:       rl = 16'($urandom) & 16'($urandom);
        2:       rl = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'hFFFF;
        default: rl = 16'($urandom);
      endcase
      b = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 31)) << 2) : ($urandom & ~32'h3);
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), rl, b,
             ($urandom_range(0, 1) == 0) ? 0 : -1, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle block-transfer engine for LDM/STM in the ARM datapath.
- Acts as the initiator side of the register-file port and the data-memory port.
- Walks a 16-bit register list in ascending order. On STM it reads registers through the regfile read port; on LDM it writes them through the regfile write port (A3/WD3/WE3).
- Performs optional base writeback at the end and stalls the core while busy.

Parameters:
- DATA_W, 32, data and address width.
- NREGS, 16, architectural register count (register-list width; index width is 4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- pre  in  1  P bit: 1 = before, 0 = after
- up  in  1  U bit: 1 = increment, 0 = decrement
- wb  in  1  W bit: base writeback enable
- rn  in  4  base register index
- reglist  in  16  register list
- base  in  32  value of Rn, sampled with start
- rf_raddr  out  4  regfile read address (STM source)
- rf_rdata  in  32  regfile read data (combinational; R15 returns PC+8)
- rf_waddr  out  4  regfile write address
- rf_wdata  out  32  regfile write data
- rf_we  out  1  regfile write enable
- pc_we  out  1  load to PC
- pc_wdata  out  32  new PC value
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address
- mem_wdata  out  32  store data
- mem_ack  in  1  transfer complete
- mem_rdata  in  32  load data, valid when mem_ack = 1
- busy  out  1  state != IDLE; core stall
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including rf_raddr, rf_waddr, mem_addr, mem_wdata, rf_wdata and pc_wdata.
- States and transitions:
  - IDLE: start=1 → SETUP. Capture is_load, pre, up, wb, rn, reglist and base.
  - SETUP (1 cycle): cnt = popcount(reglist), 0..16.
    - Start address: IA = base; IB = base+4; DA = base-4*cnt+4; DB = base-4*cnt.
    - Final base: up ? base+4*cnt : base-4*cnt.
    - All arithmetic is modulo 2^32.
    - cnt == 0 → DONE. No memory access, no writes.
    - Otherwise → XFER.
  - XFER:
    - mem_req=1. mem_addr = current address. cur = lowest set bit of the remaining mask.
    - STM: mem_we=1, rf_raddr=cur, mem_wdata=rf_rdata.
    - mem_addr, mem_we and mem_wdata are held stable until mem_ack.
    - mem_ack may arrive in the first request cycle; 1 cycle per transfer minimum.
    - On ack: clear cur from the mask; address += 4. Transfers are always ascending regardless of up.
    - LDM only, on ack: register (cur, mem_rdata) into the write-pending holding regs.
    - Mask becomes empty on ack → FLUSH.
  - Pending load write (LDM): applied in the cycle after its ack, overlapping the next XFER.
    - cur != 15: rf_we=1, rf_waddr=cur, rf_wdata=data.
    - cur == 15: pc_we=1 and pc_wdata = data & ~3; rf_we stays 0.
  - FLUSH (1 cycle): drains the last pending load write (nothing on STM) → WB.
  - WB (1 cycle):
    - Base write rf_we=1, rf_waddr=rn, rf_wdata = final base, only if wb=1.
    - Suppressed when is_load=1 and reglist[rn]=1 (loaded value wins).
    - Suppressed when rn==15.
    - → DONE.
  - DONE: done=1 for 1 cycle → IDLE.
- Latency: start accepted at T0, n zero-wait transfers → done at T0+4+n. With cnt==0 → done at T0+2.
- Store semantics: STM with R15 in the list stores PC+8 (from the regfile). STM with rn in the list stores the original base, because writeback happens after all transfers.
- Strobes: rf_we and pc_we are never both 1. rf_we is at most one pulse per cycle.
- start while busy: ignored; no queueing.
- rst mid-operation: immediate return to IDLE; outstanding mem_req drops; no further writes.

Decomposition:
- Shared package arm_pkg:
  - State enum: IDLE, SETUP, XFER, FLUSH, WB, DONE.
  - Constants PC_IDX=4'd15 and WORD_BYTES=4.
  - Addressing-mode encodings (IA/IB/DA/DB from {pre, up}).
- Sub-module: reglist_scan. Combinational popcount plus lowest-set-bit priority encoder over 16 bits, outputs cnt[4:0], idx[3:0], any.

Test Plan:
- STM IA, base=0x100, reglist=0x000E, R1..R3 = 1, 2, 3, zero-wait ack → stores (0x100,1), (0x104,2), (0x108,3); no writes; done at T7.
- LDM DB with wb, rn=13, base=0x200, reglist=0x0003, mem returns 0xAA, 0xBB → reads at 0x1F8 and 0x1FC; R0=0xAA, R1=0xBB; R13=0x1F8 in WB.
- LDM IB, reglist=0x8001, base=0x40, mem_ack delayed 3 cycles each → addresses 0x44 and 0x48, held stable while waiting; R0 written; pc_we with 0x48 data & ~3; rf_we never set for index 15.
- LDM with wb, rn=2, reglist=0x0004, data 0x55 → R2=0x55; no base writeback.
- reglist=0, start → no mem_req, no writes; done at T0+2. start pulsed while busy → ignored.
- rst asserted during 2nd of 4 transfers → outputs 0 next edge; no rf_we afterwards; a new start completes normally.
